// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, ALU operations, control bundle and
// immediate formats, plus small opcode classification helpers.
package riscv_pkg;

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011
   } opcode_t;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_t;

   typedef struct packed {
      logic reg_wr;
      logic mem_rd;
      logic mem_wr;
      logic branch;
      logic jump;
      logic alu_src;
      logic illegal;
   } ctrl_t;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_type_t;

   function automatic imm_type_t imm_type_of(input logic [6:0] opcode);
      case (opcode)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR: return IMM_I;
         OPC_STORE:                      return IMM_S;
         OPC_BRANCH:                     return IMM_B;
         OPC_LUI, OPC_AUIPC:             return IMM_U;
         OPC_JAL:                        return IMM_J;
         default:                        return IMM_NONE;
      endcase
   endfunction

   function automatic logic uses_rs1(input logic [6:0] opcode);
      return !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opcode);
      return (opcode == OPC_OP || opcode == OPC_BRANCH || opcode == OPC_STORE);
   endfunction

   // funct7[5] selects SUB only for register-register ops; SRA/SRL for both.
   function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt,
                                          input logic is_imm);
      case (funct3)
         3'b000:  return (alt && !is_imm) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects the RV32I immediate format from the opcode and
// sign-extends from instr[31] to XLEN.
module imm_gen
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      imm32 = '0;
      case (imm_type_of(instr[6:0]))
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
         IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_issue.sv
// RV32I decode/issue stage: decodes, bypasses writeback, detects load-use
// hazards and registers the result into the ID/EX register with valid/ready.
module decode_issue
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            if_valid,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_ready,
   input  logic            flush,
   output logic [4:0]      read_reg1,
   output logic [4:0]      read_reg2,
   input  logic [XLEN-1:0] rd1,
   input  logic [XLEN-1:0] rd2,
   input  logic            wb_wr_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            ex_ready,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [3:0]      ex_alu_op,
   output logic [2:0]      ex_funct3,
   output logic            ex_reg_wr,
   output logic            ex_mem_rd,
   output logic            ex_mem_wr,
   output logic            ex_branch,
   output logic            ex_jump,
   output logic            ex_alu_src,
   output logic            ex_illegal
);

   typedef struct packed {
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      alu_op_t         alu_op;
      logic [2:0]      funct3;
      ctrl_t           ctrl;
   } idex_t;

   logic [6:0] opcode;
   logic [4:0] rs1, rs2, rd;
   logic [2:0] funct3;
   logic       funct7_b5;

   assign opcode    = if_instr[6:0];
   assign rd        = if_instr[11:7];
   assign funct3    = if_instr[14:12];
   assign rs1       = if_instr[19:15];
   assign rs2       = if_instr[24:20];
   assign funct7_b5 = if_instr[30];
   assign read_reg1 = rs1;
   assign read_reg2 = rs2;

   logic [XLEN-1:0] imm;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (if_instr),
      .imm   (imm)
   );

   ctrl_t   ctrl;
   alu_op_t alu_op;

   always_comb begin
      ctrl   = '0;
      alu_op = ALU_ADD;
      case (opcode)
         OPC_LUI:    begin ctrl.reg_wr = 1'b1; ctrl.alu_src = 1'b1; alu_op = ALU_PASSB; end
         OPC_AUIPC:  begin ctrl.reg_wr = 1'b1; ctrl.alu_src = 1'b1; end
         OPC_JAL:    begin ctrl.reg_wr = 1'b1; ctrl.jump = 1'b1; end
         OPC_JALR:   begin ctrl.reg_wr = 1'b1; ctrl.jump = 1'b1; ctrl.alu_src = 1'b1; end
         OPC_BRANCH: begin ctrl.branch = 1'b1; alu_op = ALU_SUB; end
         OPC_LOAD:   begin ctrl.reg_wr = 1'b1; ctrl.mem_rd = 1'b1; ctrl.alu_src = 1'b1; end
         OPC_STORE:  begin ctrl.mem_wr = 1'b1; ctrl.alu_src = 1'b1; end
         OPC_OP_IMM: begin
            ctrl.reg_wr  = 1'b1;
            ctrl.alu_src = 1'b1;
            alu_op       = alu_decode(funct3, funct7_b5, 1'b1);
         end
         OPC_OP:     begin
            ctrl.reg_wr = 1'b1;
            alu_op      = alu_decode(funct3, funct7_b5, 1'b0);
         end
         default:    ctrl.illegal = 1'b1;
      endcase
   end

   // x0 reads as zero; otherwise the value being written back this cycle wins.
   logic [XLEN-1:0] rs1_data, rs2_data;
   assign rs1_data = (rs1 == 5'd0) ? '0 : (wb_wr_en && wb_rd == rs1) ? wb_data : rd1;
   assign rs2_data = (rs2 == 5'd0) ? '0 : (wb_wr_en && wb_rd == rs2) ? wb_data : rd2;

   idex_t           ex_q, ex_d, dec;
   logic            ex_valid_q, ex_valid_d;
   logic [XLEN-1:0] ex_pc_q, ex_pc_d;
   logic            load_en, hazard;

   assign load_en = !ex_valid_q || ex_ready;
   assign hazard  = if_valid && ex_valid_q && ex_q.ctrl.mem_rd && (ex_q.rd != 5'd0) &&
                    ((uses_rs1(opcode) && rs1 == ex_q.rd) ||
                     (uses_rs2(opcode) && rs2 == ex_q.rd));
   assign if_ready = flush || (load_en && !hazard);

   always_comb begin
      dec.rs1_data = rs1_data;
      dec.rs2_data = rs2_data;
      dec.imm      = imm;
      dec.rs1      = rs1;
      dec.rs2      = rs2;
      dec.rd       = rd;
      dec.alu_op   = alu_op;
      dec.funct3   = funct3;
      dec.ctrl     = ctrl;
   end

   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_pc_d    = ex_pc_q;
      ex_d       = ex_q;
      if (flush) begin
         ex_valid_d = 1'b0;
      end else if (load_en && hazard) begin
         ex_valid_d = 1'b0;
      end else if (load_en) begin
         ex_valid_d = if_valid;
         ex_pc_d    = if_pc;
         ex_d       = dec;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!n_rst) begin
         ex_valid_q <= 1'b0;
         ex_pc_q    <= RESET_PC;
         ex_q       <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_pc_q    <= ex_pc_d;
         ex_q       <= ex_d;
      end
   end

   assign ex_valid    = ex_valid_q;
   assign ex_pc       = ex_pc_q;
   assign ex_rs1_data = ex_q.rs1_data;
   assign ex_rs2_data = ex_q.rs2_data;
   assign ex_imm      = ex_q.imm;
   assign ex_rs1      = ex_q.rs1;
   assign ex_rs2      = ex_q.rs2;
   assign ex_rd       = ex_q.rd;
   assign ex_alu_op   = ex_q.alu_op;
   assign ex_funct3   = ex_q.funct3;
   assign ex_reg_wr   = ex_q.ctrl.reg_wr;
   assign ex_mem_rd   = ex_q.ctrl.mem_rd;
   assign ex_mem_wr   = ex_q.ctrl.mem_wr;
   assign ex_branch   = ex_q.ctrl.branch;
   assign ex_jump     = ex_q.ctrl.jump;
   assign ex_alu_src  = ex_q.ctrl.alu_src;
   assign ex_illegal  = ex_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: expected ID/EX contents are queued on
// acceptance and compared when execute takes the instruction.
module tb_decode_issue;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk, n_rst;
   logic        if_valid, if_ready, flush, ex_ready, wb_wr_en, ex_valid;
   logic [31:0] if_instr, if_pc, rd1, rd2, wb_data;
   logic [4:0]  wb_rd, read_reg1, read_reg2;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [3:0]  ex_alu_op;
   logic [2:0]  ex_funct3;
   logic        ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump, ex_alu_src, ex_illegal;

   decode_issue #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .n_rst(n_rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .if_ready(if_ready), .flush(flush), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .rd1(rd1), .rd2(rd2), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3), .ex_reg_wr(ex_reg_wr),
      .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_alu_src(ex_alu_src), .ex_illegal(ex_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] pc, a, b, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  alu;
      logic [2:0]  f3;
      logic [6:0]  ctrl;  // {reg_wr, mem_rd, mem_wr, branch, jump, alu_src, illegal}
   } exp_t;

   exp_t sb[$];

   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] r1, input logic [31:0] r2,
                                  input logic wen, input logic [4:0] wrd, input logic [31:0] wd);
      exp_t e;
      logic [6:0] opc;
      logic [3:0] f3_alu;
      opc   = ins[6:0];
      e.pc  = pc;
      e.rs1 = ins[19:15];
      e.rs2 = ins[24:20];
      e.rd  = ins[11:7];
      e.f3  = ins[14:12];
      e.a   = (e.rs1 == 0) ? 32'h0 : (wen && wrd == e.rs1) ? wd : r1;
      e.b   = (e.rs2 == 0) ? 32'h0 : (wen && wrd == e.rs2) ? wd : r2;
      case (e.f3)
         3'd0: f3_alu = (opc == 7'h33 && ins[30]) ? 4'd1 : 4'd0;
         3'd1: f3_alu = 4'd2;
         3'd2: f3_alu = 4'd3;
         3'd3: f3_alu = 4'd4;
         3'd4: f3_alu = 4'd5;
         3'd5: f3_alu = ins[30] ? 4'd7 : 4'd6;
         3'd6: f3_alu = 4'd8;
         default: f3_alu = 4'd9;
      endcase
      case (opc)
         7'h37: begin e.ctrl = 7'b1000010; e.alu = 4'd10; e.imm = {ins[31:12], 12'h000}; end
         7'h17: begin e.ctrl = 7'b1000010; e.alu = 4'd0;  e.imm = {ins[31:12], 12'h000}; end
         7'h6F: begin e.ctrl = 7'b1000100; e.alu = 4'd0;
                      e.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}; end
         7'h67: begin e.ctrl = 7'b1000110; e.alu = 4'd0;  e.imm = {{20{ins[31]}}, ins[31:20]}; end
         7'h63: begin e.ctrl = 7'b0001000; e.alu = 4'd1;
                      e.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}; end
         7'h03: begin e.ctrl = 7'b1100010; e.alu = 4'd0;  e.imm = {{20{ins[31]}}, ins[31:20]}; end
         7'h23: begin e.ctrl = 7'b0010010; e.alu = 4'd0;
                      e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
         7'h13: begin e.ctrl = 7'b1000010; e.alu = f3_alu; e.imm = {{20{ins[31]}}, ins[31:20]}; end
         7'h33: begin e.ctrl = 7'b1000000; e.alu = f3_alu; e.imm = 32'h0; end
         default: begin e.ctrl = 7'b0000001; e.alu = 4'd0; e.imm = 32'h0; end
      endcase
      return e;
   endfunction

   // Departure compares the oldest entry; a flushed stalled entry is dropped.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (n_rst) begin
         if (ex_valid && (ex_ready || flush)) begin
            if (sb.size() == 0) begin
               check("spurious_ex_valid", 32'(ex_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               if (ex_ready) begin
                  check("sb_pc",   ex_pc, e.pc);
                  check("sb_a",    ex_rs1_data, e.a);
                  check("sb_b",    ex_rs2_data, e.b);
                  check("sb_imm",  ex_imm, e.imm);
                  check("sb_rs1",  32'(ex_rs1), 32'(e.rs1));
                  check("sb_rs2",  32'(ex_rs2), 32'(e.rs2));
                  check("sb_rd",   32'(ex_rd), 32'(e.rd));
                  check("sb_alu",  32'(ex_alu_op), 32'(e.alu));
                  check("sb_f3",   32'(ex_funct3), 32'(e.f3));
                  check("sb_ctrl", 32'({ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump,
                                        ex_alu_src, ex_illegal}), 32'(e.ctrl));
               end
            end
         end
         if (if_valid && if_ready && !flush)
            sb.push_back(model(if_instr, if_pc, rd1, rd2, wb_wr_en, wb_rd, wb_data));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
      if_valid = 1'b1;
      if_instr = ins;
      if_pc    = pc;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, 32'(ex_valid), 32'd0);
      check({tag, "_pc"}, ex_pc, RST_PC);
      check({tag, "_imm"}, ex_imm, 32'd0);
      check({tag, "_ops"}, ex_rs1_data | ex_rs2_data, 32'd0);
      check({tag, "_ctrl"}, 32'({ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump,
                                 ex_alu_src, ex_illegal, ex_alu_op, ex_funct3,
                                 ex_rd, ex_rs1, ex_rs2}), 32'd0);
   endtask

   logic [31:0] misc [8] = '{32'h40208433, 32'h4030D493, 32'hC0008093, 32'h0020A423,
                             32'hFFDFF0EF, 32'h00008067, 32'h00001297, 32'h0020C1B3};

   initial begin
      n_rst = 1'b0; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0; flush = 1'b0;
      ex_ready = 1'b1; rd1 = 32'h0; rd2 = 32'h0; wb_wr_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      tick();
      n_rst = 1'b1;

      // addi x1,x0,5
      rd1 = 32'h1111; rd2 = 32'h2222;
      drive(32'h00500093, 32'h100);
      @(negedge clk);
      check("read_reg1", 32'(read_reg1), 32'd0);
      check("read_reg2", 32'(read_reg2), 32'd5);
      check("addi_ready", 32'(if_ready), 32'd1);
      tick();
      // beq x0,x0,-4
      drive(32'hFE000EE3, 32'h104);
      @(negedge clk);
      check("addi_valid", 32'(ex_valid), 32'd1);
      check("addi_imm", ex_imm, 32'd5);
      check("addi_alu", 32'(ex_alu_op), 32'd0);
      check("addi_src", 32'({ex_reg_wr, ex_alu_src}), 32'd3);
      tick();
      // lw x2,0(x1) then add x3,x2,x2
      drive(32'h0000A103, 32'h108);
      @(negedge clk);
      check("beq_imm", ex_imm, 32'hFFFF_FFFC);
      check("beq_ctrl", 32'({ex_branch, ex_reg_wr}), 32'd2);
      check("beq_ops", ex_rs1_data | ex_rs2_data, 32'd0);
      tick();
      drive(32'h002101B3, 32'h10C);
      rd1 = 32'hAAAA_0000; rd2 = 32'hAAAA_0000;
      @(negedge clk);
      check("hazard_ready", 32'(if_ready), 32'd0);
      check("lw_valid", 32'(ex_valid), 32'd1);
      tick();
      wb_wr_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h1234_5678;
      @(negedge clk);
      check("bubble_valid", 32'(ex_valid), 32'd0);
      check("hazard_release", 32'(if_ready), 32'd1);
      tick();
      wb_wr_en = 1'b0;
      drive(32'h00002403, 32'h110);  // lw x8,0(x0)
      @(negedge clk);
      check("add_valid", 32'(ex_valid), 32'd1);
      check("add_pc", ex_pc, 32'h10C);
      check("add_bypass", ex_rs2_data, 32'h1234_5678);
      tick();
      drive(32'h12345537, 32'h114);  // lui: rs1 field 8, but no rs1 use
      @(negedge clk);
      check("lui_no_hazard", 32'(if_ready), 32'd1);
      tick();
      drive(32'h00002003, 32'h118);  // lw x0
      tick();
      drive(32'h000001B3, 32'h11C);  // add x3,x0,x0
      @(negedge clk);
      check("x0_no_hazard", 32'(if_ready), 32'd1);
      tick();

      // writeback bypass on rs1, then x0 must beat a matching writeback
      rd1 = 32'h0; wb_wr_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
      drive(32'h00128313, 32'h120);
      tick();
      wb_rd = 5'd0; wb_data = 32'h55; rd2 = 32'h77;
      drive(32'h005003B3, 32'h124);
      @(negedge clk);
      check("bypass_rs1", ex_rs1_data, 32'hDEAD_BEEF);
      tick();
      wb_wr_en = 1'b0; rd1 = 32'h8000_0000; rd2 = 32'h3;
      for (int i = 0; i < 8; i++) begin
         drive(misc[i], 32'h140 + 32'(4 * i));
         tick();
      end

      // stall with a flush in the second stalled cycle
      drive(32'h00500093, 32'h200);
      tick();
      drive(32'h00128313, 32'h204);
      ex_ready = 1'b0;
      @(negedge clk);
      check("stall1_valid", 32'(ex_valid), 32'd1);
      check("stall1_ready", 32'(if_ready), 32'd0);
      check("stall1_pc", ex_pc, 32'h200);
      tick();
      flush = 1'b1;
      @(negedge clk);
      check("stall2_valid", 32'(ex_valid), 32'd1);
      check("stall2_pc", ex_pc, 32'h200);
      check("stall2_imm", ex_imm, 32'd5);
      check("stall2_rd", 32'({ex_rd, ex_reg_wr}), 32'({5'd1, 1'b1}));
      check("flush_ready", 32'(if_ready), 32'd1);
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("flushed_valid", 32'(ex_valid), 32'd0);
      check("post_flush_ready", 32'(if_ready), 32'd1);
      tick();
      ex_ready = 1'b1; if_valid = 1'b0;
      tick();

      // illegal word, then reset while stalled
      drive(32'hFFFF_FFFF, 32'h300);
      tick();
      drive(32'h00500093, 32'h304);
      @(negedge clk);
      check("illegal_flag", 32'(ex_illegal), 32'd1);
      check("illegal_ctrl", 32'({ex_reg_wr, ex_mem_wr}), 32'd0);
      tick();
      if_valid = 1'b0; ex_ready = 1'b0;
      @(negedge clk);
      check("held_valid", 32'(ex_valid), 32'd1);
      #2;
      n_rst = 1'b0;
      #1;
      check_reset_state("midreset");
      sb.delete();
      tick();
      n_rst = 1'b1; ex_ready = 1'b1;
      wb_wr_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h0BAD_F00D;
      drive(32'h00128313, 32'h400);
      tick();
      if_valid = 1'b0; wb_wr_en = 1'b0;
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      check("drain", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
